// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions used by the fetch-side units.
// Holds the PC FSM encoding and PC-related constants.
package rv32i_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HALT  = 2'd1,
      FAULT = 2'd2
   } pc_state_t;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_unit.sv
// Program counter unit: sequential fetch, redirects, stall, halt
// and misaligned-target fault detection with a retire counter.
module pc_unit
   import rv32i_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        NextPCSrc,
   input  logic [31:0] alu_res,
   input  logic        stall,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        halted,
   output logic        misaligned,
   output logic [31:0] fault_addr,
   output logic [31:0] retired
);

   pc_state_t   state;
   pc_state_t   state_n;
   logic [31:0] pc_n;
   logic [31:0] retired_n;
   logic [31:0] fault_n;
   logic [31:0] target;

   assign pc_plus4   = pc + PC_INC;
   assign halted     = (state != RUN);
   assign misaligned = (state == FAULT);

   // Next-state and next-pc selection; bit 0 of the target is
   // dropped before the alignment check, so only bit 1 can fault.
   always_comb begin
      state_n   = state;
      pc_n      = pc;
      retired_n = retired;
      fault_n   = fault_addr;
      target    = alu_res & ~32'd1;
      case (state)
         RUN: begin
            if (!stall) begin
               if (halt_req) begin
                  state_n = HALT;
               end else if (NextPCSrc && target[1]) begin
                  state_n = FAULT;
                  fault_n = target;
               end else begin
                  pc_n      = NextPCSrc ? target : pc_plus4;
                  retired_n = retired + 32'd1;
               end
            end
         end
         HALT, FAULT: begin
            state_n = state;
         end
         default: begin
            state_n = RUN;
         end
      endcase
   end

   // State register with synchronous reset taking priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pc         <= RESET_PC;
         retired    <= 32'd0;
         fault_addr <= 32'd0;
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         retired    <= retired_n;
         fault_addr <= fault_n;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit with a scoreboard queue of expected
// post-edge values; a second instance covers the address wrap.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        nps;
   logic [31:0] alu_res;
   logic        stall;
   logic        halt_req;

   logic [31:0] a_pc, a_pc4, a_fa, a_ret;
   logic        a_halted, a_mis;
   logic [31:0] b_pc, b_pc4, b_fa, b_ret;
   logic        b_halted, b_mis;

   int checks = 0;
   int fails  = 0;

   typedef struct {
      string       tag;
      bit          sel;
      logic [31:0] pc;
      logic [31:0] ret;
      logic        halted;
      logic        mis;
      logic [31:0] fa;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   pc_unit u_a (
      .clk(clk), .rst(rst), .NextPCSrc(nps), .alu_res(alu_res),
      .stall(stall), .halt_req(halt_req), .pc(a_pc),
      .pc_plus4(a_pc4), .halted(a_halted), .misaligned(a_mis),
      .fault_addr(a_fa), .retired(a_ret)
   );

   pc_unit #(.RESET_PC(32'hFFFF_FFF8)) u_b (
      .clk(clk), .rst(rst), .NextPCSrc(nps), .alu_res(alu_res),
      .stall(stall), .halt_req(halt_req), .pc(b_pc),
      .pc_plus4(b_pc4), .halted(b_halted), .misaligned(b_mis),
      .fault_addr(b_fa), .retired(b_ret)
   );

   task automatic chk(input string tag, input string fld,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
      end
   endtask

   task automatic step(input string tag, input bit sel,
                       input logic r, input logic s, input logic h,
                       input logic n, input logic [31:0] a,
                       input logic [31:0] epc, input logic [31:0] eret,
                       input logic eh, input logic em,
                       input logic [31:0] efa);
      exp_t e;
      rst = r; stall = s; halt_req = h; nps = n; alu_res = a;
      e.tag = tag; e.sel = sel; e.pc = epc; e.ret = eret;
      e.halted = eh; e.mis = em; e.fa = efa;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      if (!e.sel) begin
         chk(e.tag, "pc", a_pc, e.pc);
         chk(e.tag, "pc4", a_pc4, e.pc + 32'd4);
         chk(e.tag, "ret", a_ret, e.ret);
         chk(e.tag, "halted", {31'd0, a_halted}, {31'd0, e.halted});
         chk(e.tag, "mis", {31'd0, a_mis}, {31'd0, e.mis});
         chk(e.tag, "fa", a_fa, e.fa);
      end else begin
         chk(e.tag, "pc", b_pc, e.pc);
         chk(e.tag, "pc4", b_pc4, e.pc + 32'd4);
         chk(e.tag, "ret", b_ret, e.ret);
         chk(e.tag, "halted", {31'd0, b_halted}, {31'd0, e.halted});
         chk(e.tag, "mis", {31'd0, b_mis}, {31'd0, e.mis});
         chk(e.tag, "fa", b_fa, e.fa);
      end
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; halt_req = 1'b0;
      nps = 1'b0; alu_res = 32'd0;
      @(negedge clk);
      // reset and sequential fetch
      step("reset",  0, 1,0,0,0, 32'h0,   32'h0,   0, 0,0, 32'h0);
      step("seq1",   0, 0,0,0,0, 32'h0,   32'h4,   1, 0,0, 32'h0);
      step("seq2",   0, 0,0,0,0, 32'h0,   32'h8,   2, 0,0, 32'h0);
      step("seq3",   0, 0,0,0,0, 32'h0,   32'hC,   3, 0,0, 32'h0);
      // redirect with LSB set at pc=8
      step("rst2",   0, 1,0,0,0, 32'h0,   32'h0,   0, 0,0, 32'h0);
      step("seq4",   0, 0,0,0,0, 32'h0,   32'h4,   1, 0,0, 32'h0);
      step("seq5",   0, 0,0,0,0, 32'h0,   32'h8,   2, 0,0, 32'h0);
      step("jmp",    0, 0,0,0,1, 32'h101, 32'h100, 3, 0,0, 32'h0);
      // stall holds a pending redirect
      step("stall1", 0, 0,1,0,1, 32'h200, 32'h100, 3, 0,0, 32'h0);
      step("stall2", 0, 0,1,0,1, 32'h200, 32'h100, 3, 0,0, 32'h0);
      step("unstl",  0, 0,0,0,1, 32'h200, 32'h200, 4, 0,0, 32'h0);
      // misaligned target faults and is terminal
      step("fault",  0, 0,0,0,1, 32'h206, 32'h200, 4, 1,1, 32'h206);
      step("fidle",  0, 0,0,0,0, 32'h0,   32'h200, 4, 1,1, 32'h206);
      step("fjmp",   0, 0,0,0,1, 32'h300, 32'h200, 4, 1,1, 32'h206);
      step("fhalt",  0, 0,1,1,1, 32'h20A, 32'h200, 4, 1,1, 32'h206);
      // reset wins over everything and clears the fault
      step("rstf",   0, 1,1,1,1, 32'h206, 32'h0,   0, 0,0, 32'h0);
      // bit 0 alone does not fault
      step("odd",    0, 0,0,0,1, 32'h11,  32'h10,  1, 0,0, 32'h0);
      // halt beats a same-cycle redirect to a misaligned target
      step("halt",   0, 0,0,1,1, 32'h402, 32'h10,  1, 1,0, 32'h0);
      step("hidle",  0, 0,0,0,0, 32'h0,   32'h10,  1, 1,0, 32'h0);
      step("hjmp",   0, 0,0,0,1, 32'h500, 32'h10,  1, 1,0, 32'h0);
      step("rsth",   0, 1,1,1,1, 32'h500, 32'h0,   0, 0,0, 32'h0);
      // stall beats halt
      step("sthalt", 0, 0,1,1,0, 32'h0,   32'h0,   0, 0,0, 32'h0);
      // wrap-around with a high reset vector
      step("brst",   1, 1,0,0,0, 32'h0, 32'hFFFF_FFF8, 0, 0,0, 32'h0);
      step("bseq1",  1, 0,0,0,0, 32'h0, 32'hFFFF_FFFC, 1, 0,0, 32'h0);
      step("bseq2",  1, 0,0,0,0, 32'h0, 32'h0000_0000, 2, 0,0, 32'h0);
      checks++;
      assert (sb.size() == 0) else begin
         fails++;
         $error("FAIL sb_empty observed=%0d expected=0", sb.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, fails);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have a parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port NextPCSrc, input, 1 bit: from the branch unit; 1 selects the jump/branch target, 0 selects pc+4.
REQ-005 The block SHALL have port alu_res, input, 32 bits: target address computed by the ALU.
REQ-006 The block SHALL have port stall, input, 1 bit: hold the PC this cycle.
REQ-007 The block SHALL have port halt_req, input, 1 bit: from the control unit on EBREAK/ECALL; stops fetch.
REQ-008 The block SHALL have port pc, output, 32 bits: current instruction address.
REQ-009 The block SHALL have port pc_plus4, output, 32 bits: pc+4, used for JAL/JALR link writeback.
REQ-010 The block SHALL have port halted, output, 1 bit: high in HALT or FAULT.
REQ-011 The block SHALL have port misaligned, output, 1 bit: high only in FAULT.
REQ-012 The block SHALL have port fault_addr, output, 32 bits: the offending target address.
REQ-013 The block SHALL have port retired, output, 32 bits: count of accepted PC advances.

Function
REQ-014 The block SHALL drive pc_plus4 = pc + 32'd4 combinationally, modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-015 The block SHALL form target = {alu_res[31:1], 1'b0}, clearing the LSB for all redirects.
REQ-016 The block SHALL implement a 3-state FSM: RUN, HALT and FAULT.
REQ-017 In RUN, with the conditions evaluated in this priority order, the block SHALL behave as follows:
- stall=1: pc, retired and state hold.
- else halt_req=1: go to HALT; pc holds.
- else NextPCSrc=1 and target[1]=1: go to FAULT; pc holds; fault_addr <= target.
- else: pc <= NextPCSrc ? target : pc_plus4, and retired <= retired+1 (wraps at 2^32).
REQ-018 HALT and FAULT SHALL be terminal until rst; pc, retired and fault_addr hold regardless of stall, halt_req or NextPCSrc.
REQ-019 When NextPCSrc and halt_req are high in the same cycle (no stall), halt SHALL win: the PC does not redirect and no fault is raised.
REQ-020 Latency SHALL be one cycle: a decision sampled at edge N appears on pc after edge N.
REQ-021 The block SHALL drive halted = (state != RUN) and misaligned = (state == FAULT) as decodes of the state register.
REQ-022 An alu_res with bit 0 set SHALL NOT by itself raise a fault, because bit 0 is cleared before the check.

Reset
REQ-023 On rst=1 at a rising clk edge, the block SHALL set pc=RESET_PC, state=RUN, retired=0 and fault_addr=0; hence halted=0 and misaligned=0.
REQ-024 rst SHALL take priority over stall, halt_req and NextPCSrc, and SHALL recover the block from HALT and FAULT.
REQ-025 Outputs SHALL be defined from the first reset edge onward; no asynchronous path from rst is permitted.

Structure
REQ-026 The shared package rv32i_pkg SHALL hold the enum pc_state_t (RUN, HALT, FAULT), the constant PC_INC = 32'd4 and the constant DEFAULT_RESET_PC.
REQ-027 The block SHALL be a single module with no sub-module: one always_ff for pc, state, retired and fault_addr, plus one always_comb for next-state and next-pc.
REQ-028 The block SHALL have no latches, and every case statement SHALL include a default arm that returns the FSM to RUN-hold behaviour.

Verification
REQ-029 Reset then 3 idle cycles with NextPCSrc=0 -> pc = 0x0, 0x4, 0x8, 0xC; retired = 3; pc_plus4 = 0x10.
REQ-030 At pc=0x8, NextPCSrc=1 and alu_res=0x0000_0101 -> next pc = 0x100, pc_plus4 = 0x104, retired increments.
REQ-031 NextPCSrc=1 and alu_res=0x0000_0206 -> FAULT: misaligned=1, halted=1, fault_addr=0x206, pc unchanged; subsequent inputs are ignored until rst.
REQ-032 stall=1 for 2 cycles together with NextPCSrc=1 -> pc and retired are frozen; on stall release the redirect is taken.
REQ-033 halt_req=1 and NextPCSrc=1 in the same cycle -> HALT, pc unchanged, misaligned=0; a later rst returns to pc=RESET_PC.
REQ-034 With RESET_PC=0xFFFF_FFF8, run 2 cycles -> pc = 0xFFFF_FFFC then 0x0000_0000 (wrap).
